// File: rtl/reg_file_dump_pkg.sv
// Shared definitions for the register file and its debug dump engine.
//   REG_COUNT    : number of architectural registers
//   REG_ZERO     : index of the hard-wired zero register
//   dump_state_e : dump engine state encoding
package reg_file_dump_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_file_dump_fsm.sv
// Dump sequencer: walks indices 0..2**AW-1 over a valid/ready handshake.
//   clk_i, rst_i     : clock, async active-high reset
//   dump_req_i       : start pulse (ignored unless idle)
//   dump_ready_i     : sink accepts current word
//   dump_valid_o     : current word valid
//   dump_idx_o       : index of current word
//   dump_done_o      : one-cycle pulse after the last word is accepted
//   busy_o           : engine not idle
//   load_o           : strobe to capture the word at load_idx_o into dump_data
//   load_idx_o       : index of the word to capture at this edge
module reg_dump_fsm
  import reg_file_dump_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dump_req_i,
  input  logic          dump_ready_i,
  output logic          dump_valid_o,
  output logic [AW-1:0] dump_idx_o,
  output logic          dump_done_o,
  output logic          busy_o,
  output logic          load_o,
  output logic [AW-1:0] load_idx_o
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_o     = 1'b0;
    load_idx_o = idx_q;
    case (state_q)
      IDLE: begin
        if (dump_req_i) begin
          state_d    = SEND;
          idx_d      = '0;
          load_o     = 1'b1;
          load_idx_o = '0;
        end
      end
      SEND: begin
        if (dump_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d      = idx_q + AW'(1);
            load_o     = 1'b1;
            load_idx_o = idx_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign dump_valid_o = (state_q == SEND);
  assign dump_done_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign dump_idx_o   = idx_q;

endmodule

// File: rtl/reg_file_dump.sv
// 2**AW x DW register file with x0 hard-wired to zero, two combinational
// read ports (optional write bypass) and a debug dump port.
//   clk, rst              : clock, async active-high reset
//   regwrite, wa, writedata : writeback port
//   ra1/rd1, ra2/rd2      : combinational read ports
//   dump_req              : start a dump of all registers
//   dump_valid/ready      : dump handshake
//   dump_idx, dump_data   : current dump word and its index
//   dump_done             : pulse after the final word is accepted
//   busy                  : dump in progress
module reg_file_dump
  import reg_file_dump_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwrite,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] writedata,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          dump_req,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  output logic          busy
);

  localparam int unsigned NREG = 2 ** AW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] dump_data_q, dump_data_d;
  logic          we;
  logic          load;
  logic [AW-1:0] load_idx;

  assign we = regwrite && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wa] <= writedata;
    end
  end

  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
    if (ra == '0)
      return '0;
    else if (BYPASS && we && (wa == ra))
      return writedata;
    else
      return regs_q[ra];
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);

  reg_dump_fsm #(
    .AW (AW)
  ) u_fsm (
    .clk_i        (clk),
    .rst_i        (rst),
    .dump_req_i   (dump_req),
    .dump_ready_i (dump_ready),
    .dump_valid_o (dump_valid),
    .dump_idx_o   (dump_idx),
    .dump_done_o  (dump_done),
    .busy_o       (busy),
    .load_o       (load),
    .load_idx_o   (load_idx)
  );

  // Snapshot taken on the edge that enters a slot; a write landing on that
  // same edge is forwarded so the word reflects the post-edge register value.
  always_comb begin
    dump_data_d = dump_data_q;
    if (load) begin
      if (we && (wa == load_idx))
        dump_data_d = writedata;
      else
        dump_data_d = regs_q[load_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dump_data_q <= '0;
    else     dump_data_q <= dump_data_d;
  end

  assign dump_data = dump_data_q;

endmodule

// File: tb/tb_reg_file_dump.sv
module tb_reg_file_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regwrite = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] writedata = '0;
  logic [4:0]  ra1 = '0, ra2 = '0;
  logic        dump_req = 1'b0, dump_ready = 1'b0;

  logic [31:0] rd1, rd2, dump_data;
  logic        dump_valid, dump_done, busy;
  logic [4:0]  dump_idx;

  logic [31:0] b_rd1, b_rd2, b_dump_data;
  logic        b_dump_valid, b_dump_done, b_busy;
  logic [4:0]  b_dump_idx;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_file_dump #(.DW(32), .AW(5), .BYPASS(1'b0)) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .wa(wa), .writedata(writedata),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done), .busy(busy)
  );

  reg_file_dump #(.DW(32), .AW(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .regwrite(regwrite), .wa(wa), .writedata(writedata),
    .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
    .dump_req(dump_req), .dump_valid(b_dump_valid), .dump_ready(dump_ready),
    .dump_idx(b_dump_idx), .dump_data(b_dump_data), .dump_done(b_dump_done), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    regwrite = 1'b1; wa = a; writedata = d;
    step();
    regwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ra1 = 5'd5; ra2 = 5'd31;
    #1;
    n_chk++; if (rd1 !== 32'd0) $display("FAIL reset_rd1 got %h exp 0", rd1); else n_pass++;
    n_chk++; if (rd2 !== 32'd0) $display("FAIL reset_rd2 got %h exp 0", rd2); else n_pass++;
    n_chk++; if ({busy, dump_valid, dump_done} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {busy, dump_valid, dump_done}); else n_pass++;
    n_chk++; if (dump_idx !== 5'd0) $display("FAIL reset_idx got %0d exp 0", dump_idx); else n_pass++;
    n_chk++; if (dump_data !== 32'd0) $display("FAIL reset_data got %h exp 0", dump_data); else n_pass++;
    step();
    rst = 1'b0;
    step();
    // write to x0 is discarded, bypass must not forward it either
    regwrite = 1'b1; wa = 5'd0; writedata = 32'hDEADBEEF; ra1 = 5'd0;
    #1;
    n_chk++; if (b_rd1 !== 32'd0) $display("FAIL x0_bypass got %h exp 0", b_rd1); else n_pass++;
    step();
    regwrite = 1'b0;
    #1;
    n_chk++; if (rd1 !== 32'd0) $display("FAIL x0_read got %h exp 0", rd1); else n_pass++;
  endtask

  task automatic test_write_read();
    regwrite = 1'b1; wa = 5'd3; writedata = 32'h12345678; ra1 = 5'd3; ra2 = 5'd3;
    #1;
    n_chk++; if (rd1 !== 32'd0) $display("FAIL nobypass_same_cycle got %h exp 0", rd1); else n_pass++;
    n_chk++; if (b_rd1 !== 32'h12345678) $display("FAIL bypass_same_cycle got %h exp 12345678", b_rd1); else n_pass++;
    step();
    regwrite = 1'b0;
    #1;
    n_chk++; if (rd1 !== 32'h12345678) $display("FAIL read_after_write rd1 got %h exp 12345678", rd1); else n_pass++;
    n_chk++; if (rd2 !== 32'h12345678) $display("FAIL read_after_write rd2 got %h exp 12345678", rd2); else n_pass++;
  endtask

  task automatic test_full_dump();
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 16));
    ra1 = 5'd31; #1;
    n_chk++; if (rd1 !== 32'd496) $display("FAIL preload_r31 got %0d exp 496", rd1); else n_pass++;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_chk++; if (dump_valid !== 1'b1) $display("FAIL full_valid k=%0d got %b exp 1", k, dump_valid); else n_pass++;
      n_chk++; if (dump_idx !== 5'(k)) $display("FAIL full_idx got %0d exp %0d", dump_idx, k); else n_pass++;
      n_chk++; if (dump_data !== 32'(k * 16)) $display("FAIL full_data k=%0d got %0d exp %0d", k, dump_data, k * 16); else n_pass++;
      step();
    end
    n_chk++; if ({dump_done, dump_valid, busy} !== 3'b101)
      $display("FAIL full_done_cycle got %b exp 101", {dump_done, dump_valid, busy}); else n_pass++;
    step();
    n_chk++; if ({dump_done, busy} !== 2'b00)
      $display("FAIL full_idle got %b exp 00", {dump_done, busy}); else n_pass++;
  endtask

  task automatic test_backpressure();
    int  c = 0;
    int  exp_idx = 0;
    bit  wrote = 0;
    bit  fin = 0;
    dump_ready = 1'b0;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    while (c < 300 && !fin) begin
      dump_ready = (c % 3 == 0);
      if (dump_valid && dump_idx == 5'd7 && !dump_ready && !wrote) begin
        regwrite = 1'b1; wa = 5'd7; writedata = 32'hFFFF0000; wrote = 1;
      end
      if (dump_done) fin = 1;
      if (dump_valid) begin
        n_chk++; if (dump_idx !== 5'(exp_idx)) $display("FAIL bp_idx got %0d exp %0d", dump_idx, exp_idx); else n_pass++;
        n_chk++; if (dump_data !== 32'(exp_idx * 16))
          $display("FAIL bp_data idx=%0d got %h exp %h", exp_idx, dump_data, 32'(exp_idx * 16)); else n_pass++;
        if (dump_ready) exp_idx++;
      end
      step();
      regwrite = 1'b0;
      c++;
    end
    n_chk++; if (fin !== 1'b1) $display("FAIL bp_done_seen got %b exp 1", fin); else n_pass++;
    n_chk++; if (exp_idx !== 32) $display("FAIL bp_word_count got %0d exp 32", exp_idx); else n_pass++;
    n_chk++; if (wrote !== 1'b1) $display("FAIL bp_stall_write_done got %b exp 1", wrote); else n_pass++;
    wr(5'd7, 32'd112);
  endtask

  task automatic test_simultaneous();
    int  words = 0;
    int  c = 0;
    bit  fin = 0;
    logic [31:0] exp_d;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    while (c < 100 && !fin) begin
      if (dump_valid && dump_idx == 5'd4) begin
        regwrite = 1'b1; wa = 5'd5; writedata = 32'hA5A5A5A5;
      end
      dump_req = (dump_valid && dump_idx == 5'd10);
      if (dump_done) fin = 1;
      if (dump_valid) begin
        exp_d = (words == 5) ? 32'hA5A5A5A5 : 32'(words * 16);
        n_chk++; if (dump_data !== exp_d) $display("FAIL sim_data idx=%0d got %h exp %h", words, dump_data, exp_d); else n_pass++;
        words++;
      end
      step();
      regwrite = 1'b0;
      dump_req = 1'b0;
      c++;
    end
    n_chk++; if (words !== 32) $display("FAIL sim_word_count got %0d exp 32", words); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL sim_no_restart busy got %b exp 0", busy); else n_pass++;
    step();
    n_chk++; if (dump_valid !== 1'b0) $display("FAIL sim_no_queue valid got %b exp 0", dump_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    int c = 0;
    bit saw_done = 0;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    while (c < 50 && dump_idx != 5'd12) begin
      step();
      c++;
    end
    n_chk++; if (dump_idx !== 5'd12) $display("FAIL ar_reach_idx12 got %0d exp 12", dump_idx); else n_pass++;
    #2;
    rst = 1'b1;
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    n_chk++; if ({busy, dump_valid} !== 2'b00) $display("FAIL ar_flags got %b exp 00", {busy, dump_valid}); else n_pass++;
    n_chk++; if (dump_idx !== 5'd0) $display("FAIL ar_idx got %0d exp 0", dump_idx); else n_pass++;
    n_chk++; if (dump_data !== 32'd0) $display("FAIL ar_data got %h exp 0", dump_data); else n_pass++;
    n_chk++; if (rd1 !== 32'd0) $display("FAIL ar_rd1 got %h exp 0", rd1); else n_pass++;
    n_chk++; if (rd2 !== 32'd0) $display("FAIL ar_rd2 got %h exp 0", rd2); else n_pass++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dump_done) saw_done = 1;
      step();
    end
    n_chk++; if (saw_done !== 1'b0) $display("FAIL ar_no_done got %b exp 0", saw_done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL ar_idle got %b exp 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_full_dump();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
- 32x32 general-purpose register file. It is the receiving end of the writeback path: it consumes the write-enable, destination index and 32-bit writeback data produced by the writeback select stage.
- Provides two combinational read ports for the single-cycle datapath.
- Provides a debug dump engine that streams all 32 registers out over a valid/ready port on request.

Parameters:
- DW, 32, register data width
- AW, 5, register index width (2**AW entries)
- BYPASS, 0, when 1 a read of the register being written in the same cycle returns writedata

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- regwrite  in  1  write enable from control
- wa  in  AW  destination register index
- writedata  in  DW  writeback value
- ra1  in  AW  read port 1 index
- ra2  in  AW  read port 2 index
- rd1  out  DW  read port 1 data (combinational)
- rd2  out  DW  read port 2 data (combinational)
- dump_req  in  1  start-dump pulse
- dump_valid  out  1  dump word available
- dump_ready  in  1  sink accepts dump word
- dump_idx  out  AW  index of current dump word
- dump_data  out  DW  current dump word
- dump_done  out  1  one-cycle pulse after last word accepted
- busy  out  1  dump engine not idle

Behaviour:
- Reset (async, rst=1): all 32 registers go to 0. State goes to IDLE. dump_valid=0, dump_idx=0, dump_data=0, dump_done=0, busy=0.
- Write:
  - On the rising clk edge with regwrite=1 and wa!=0, reg[wa] <= writedata.
  - Writes to x0 are discarded; reg[0] always reads 0.
- Read:
  - rd1 = reg[ra1] and rd2 = reg[ra2], combinational, zero latency. Index 0 returns 0.
  - BYPASS=1: if regwrite=1, wa==ra and ra!=0, the port returns writedata.
  - BYPASS=0: the port returns the old value until the edge.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE:
    - dump_req=1 -> SEND, with dump_idx=0 and dump_data=0.
    - Otherwise stay in IDLE.
  - SEND:
    - dump_valid=1.
    - Transfer occurs when dump_valid and dump_ready are both 1 on an edge.
    - On transfer with dump_idx<31: dump_idx increments and dump_data is captured from the next register.
    - On transfer with dump_idx==31 -> DONE.
    - No transfer: dump_idx and dump_data hold stable (stall).
  - DONE: dump_valid=0, dump_done=1 for exactly one cycle, then IDLE.
- Snapshot rule:
  - dump_data is a registered copy loaded at the edge that enters slot k.
  - If a write to k happens on that same edge, the captured value is writedata, not the stale value.
  - Writes to slot k after capture do not alter dump_data while stalled.
- dump_req while busy=1 is ignored; no restart and no queueing.
- busy=1 in SEND and DONE.
- Normal writes and reads continue unaffected during a dump; the dump never blocks the datapath.
- rst asserted mid-dump aborts immediately. All outputs go to their reset values and no dump_done is issued.
- dump_idx wrap: never wraps; a dump ends at 31.

Decomposition:
- Shared package holds:
  - REG_COUNT=32
  - REG_ZERO=5'd0
  - dump state encoding: IDLE=2'd0, SEND=2'd1, DONE=2'd2
- One sub-module, reg_dump_fsm: owns the state, dump_idx and handshake. It produces an index to the array and a load strobe for dump_data.
- The array and read ports remain in the top.

Test Plan:
- Reset then read: rst=1 pulse; ra1=5, ra2=31 -> rd1=0, rd2=0. Write reg0=32'hDEADBEEF, read ra1=0 -> 0.
- Write/read: write reg3=32'h12345678; next cycle ra1=3 -> 32'h12345678. Same-cycle read with BYPASS=0 -> old 0. With BYPASS=1 -> 32'h12345678.
- Full dump, ready tied high: preload reg[i]=i*16; pulse dump_req -> 32 consecutive valid cycles carrying idx 0..31 and data 0,16,...,496. Then a dump_done pulse, then busy=0 (34 cycles from req to idle).
- Backpressure: dump_ready toggles 1,0,0,1,... -> no word lost or duplicated; dump_data stable while stalled. A write to the stalled idx does not change dump_data.
- Simultaneous capture: write reg5=32'hA5A5A5A5 on the edge where dump_idx advances to 5 -> word 5 = 32'hA5A5A5A5. dump_req during SEND -> ignored, exactly 32 words.
- Async reset mid-dump: assert rst at idx 12, between edges -> busy, dump_valid and dump_idx drop to 0 immediately, all regs 0, no dump_done.
